// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux.
// A grant holds sel stable for up to MAX_BURST beats, then the search restarts after the last winner.
module mux_rr_sched #(
  parameter int N         = 8,
  parameter int SEL_W     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             out_valid,
  output logic [7:0]       beat_cnt,
  output logic             busy
);

  localparam int         CNT_W     = 8;
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [SEL_W-1:0]   ptr_r, ptr_nxt_s;
  logic [SEL_W-1:0]   sel_r, sel_nxt_s;
  logic [N-1:0]       gnt_r, gnt_nxt_s;
  logic [CNT_W-1:0]   beat_r, beat_nxt_s;
  logic               valid_s, xfer_s, release_s;
  logic [SEL_W-1:0]   search_ptr_s;
  logic [SEL_W:0]     pick_s;

  // First requester at or after p (wrapping); MSB flags that one was found.
  // Scanning from the farthest offset down lets the nearest one overwrite the result.
  function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] r, input logic [SEL_W-1:0] p);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, handshake and re-pick logic.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    sel_nxt_s    = sel_r;
    gnt_nxt_s    = gnt_r;
    beat_nxt_s   = beat_r;
    valid_s      = 1'b0;
    xfer_s       = 1'b0;
    release_s    = 1'b0;
    search_ptr_s = ptr_r;
    pick_s       = '0;
    case (state_r)
      ST_IDLE: begin
        pick_s = rr_pick(req, ptr_r);
        if (pick_s[SEL_W]) begin
          state_nxt_s = ST_GRANT;
          sel_nxt_s   = pick_s[SEL_W-1:0];
          gnt_nxt_s   = {{(N-1){1'b0}}, 1'b1} << pick_s[SEL_W-1:0];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        valid_s   = req[sel_r];
        xfer_s    = valid_s & out_ready;
        release_s = ~req[sel_r] | (xfer_s & (beat_r == LAST_BEAT));
        if (release_s) begin
          // Search from just past the releasing requester so it only wins again when alone.
          search_ptr_s = sel_r + SEL_W'(1);
          pick_s       = rr_pick(req, search_ptr_s);
          ptr_nxt_s    = search_ptr_s;
          beat_nxt_s   = '0;
          if (pick_s[SEL_W]) begin
            state_nxt_s = ST_GRANT;
            sel_nxt_s   = pick_s[SEL_W-1:0];
            gnt_nxt_s   = {{(N-1){1'b0}}, 1'b1} << pick_s[SEL_W-1:0];
          end else begin
            state_nxt_s = ST_IDLE;
            gnt_nxt_s   = '0;
          end
        end else if (xfer_s) begin
          beat_nxt_s = beat_r + 8'd1;
        end else begin
          beat_nxt_s = beat_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
        beat_nxt_s  = '0;
      end
    endcase
  end

  // State, pointer, select, grant and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      sel_r   <= '0;
      gnt_r   <= '0;
      beat_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      sel_r   <= sel_nxt_s;
      gnt_r   <= gnt_nxt_s;
      beat_r  <= beat_nxt_s;
    end
  end

  assign sel       = sel_r;
  assign gnt       = gnt_r;
  assign beat_cnt  = beat_r;
  assign out_valid = valid_s;
  assign busy      = (state_r == ST_GRANT);

endmodule
